fixedpoint_accumulator: RTL

- Sequential stage directly downstream of the fixed-point multiplier.
- Consumes its (2N-1)-bit sign-magnitude products and sums a group of LEN consecutive products as a dot product.
- Rounds and saturates the sum back to the N-bit sign-magnitude Q format used by the multiplier's inputs, so the result can feed the next multiply.
- Valid/ready handshake on both sides.

---
 rtl/fixedpoint_pkg.sv | 37 +++
 rtl/fixedpoint_requant.sv | 37 +++
 rtl/fixedpoint_accumulator.sv | 85 ++++++++
 3 files changed

// File: rtl/fixedpoint_pkg.sv
// rtl/fixedpoint_pkg.sv - shared fixed-point widths, FSM states and sign-magnitude helpers
package fixedpoint_pkg;

  localparam int N       = 8;
  localparam int Q       = 6;
  localparam int PROD_W  = 2 * N - 1;
  localparam int MAX_MAG = (1 << (N - 1)) - 1;

  // Helpers work at a fixed wide width; callers extend/slice to their own width.
  localparam int TC_W = 32;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic            sign;
    logic [TC_W-1:0] mag;
  } sm_t;

  function automatic logic signed [TC_W-1:0] sm_to_tc(input logic [TC_W-1:0] mag,
                                                      input logic sign);
    logic signed [TC_W-1:0] v;
    v = $signed(mag);
    return sign ? -v : v;
  endfunction

  function automatic sm_t tc_to_sm(input logic signed [TC_W-1:0] v);
    sm_t r;
    r.sign = v[TC_W-1];
    r.mag  = v[TC_W-1] ? $unsigned(-v) : $unsigned(v);
    return r;
  endfunction

endpackage

// File: rtl/fixedpoint_requant.sv
// rtl/fixedpoint_requant.sv - two's-complement sum to N-bit sign-magnitude with round-half-away and clipping
module fixedpoint_requant
  import fixedpoint_pkg::*;
#(
  parameter int N     = 8,
  parameter int Q     = 6,
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [N-1:0]     y,
  output logic                    sat
);

  localparam logic [TC_W-1:0] HALF    = TC_W'(1) << (Q - 1);
  localparam logic [TC_W-1:0] MAG_LIM = (TC_W'(1) << (N - 1)) - TC_W'(1);

  logic signed [TC_W-1:0] acc_ext;
  sm_t                    sm;
  logic [TC_W-1:0]        rounded;
  logic [TC_W-1:0]        mag;

  assign acc_ext = TC_W'(acc);

  always_comb begin
    sm      = tc_to_sm(acc_ext);
    rounded = (sm.mag + HALF) >> Q;
    sat     = 1'b0;
    mag     = rounded;
    if (rounded > MAG_LIM) begin
      mag = MAG_LIM;
      sat = 1'b1;
    end
    // A result that rounds to zero is always reported as +0.
    y = {sm.sign && (mag != '0), mag[N-2:0]};
  end

endmodule

// File: rtl/fixedpoint_accumulator.sv
// rtl/fixedpoint_accumulator.sv - sums LEN sign-magnitude products and requantises to N-bit Q format
module fixedpoint_accumulator
  import fixedpoint_pkg::*;
#(
  parameter int N     = 8,
  parameter int Q     = 6,
  parameter int LEN   = 4,
  parameter int ACC_W = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2*N-2:0]   i_c,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_y,
  output logic             o_sat
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        count;
  logic signed [ACC_W-1:0] acc;
  logic                    take;
  logic                    last;
  logic signed [TC_W-1:0]  addend_ext;
  logic [N-1:0]            rq_y;
  logic                    rq_sat;

  assign addend_ext = sm_to_tc(TC_W'(i_c[2*N-3:0]), i_c[2*N-2]);
  assign last       = (count == CNT_W'(LEN - 1));
  assign o_valid    = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    take    = 1'b0;
    case (state_q)
      ACCUM: begin
        o_ready = 1'b1;
        take    = i_valid;
        if (i_valid && last) state_d = ROUND;
      end
      ROUND:   state_d = HOLD;
      HOLD:    if (i_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ACCUM;
      acc     <= '0;
      count   <= '0;
      o_y     <= '0;
      o_sat   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        acc   <= acc + addend_ext[ACC_W-1:0];
        count <= last ? '0 : count + CNT_W'(1);
      end
      if (state_q == ROUND) begin
        o_y   <= rq_y;
        o_sat <= rq_sat;
      end
      // The sum is cleared only once the result has been handed off.
      if (state_q == HOLD && i_ready) acc <= '0;
    end
  end

  fixedpoint_requant #(
    .N     (N),
    .Q     (Q),
    .ACC_W (ACC_W)
  ) u_requant (
    .acc (acc),
    .y   (rq_y),
    .sat (rq_sat)
  );

endmodule
